// File: rtl/uart_pkg.sv
// Shared UART definitions: framing constants, FSM state encoding and the rx holding-register payload.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_IDX_W        = $clog2(UART_DATA_BITS);
    localparam int unsigned UART_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        s_IDLE    = 3'd0,
        s_START   = 3'd1,
        s_DATA    = 3'd2,
        s_STOP    = 3'd3,
        s_CLEANUP = 3'd4
    } uart_state_t;

    // One-entry receive holding register
    typedef struct packed {
        logic                      dv;
        logic                      overrun;
        logic [UART_DATA_BITS-1:0] data;
    } uart_hold_t;

    // Counter value at which the middle of a bit period is reached
    function automatic int unsigned uart_mid_bit(input int unsigned clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the async serial line plus a previous-value flop for falling-edge detect.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_serial,
    output logic rx_s,
    output logic fall
);

    logic meta;
    logic rx_q;
    logic prev;

    // Idle line level is high, so every stage resets to 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b1;
            rx_q <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= rx_serial;
            rx_q <= meta;
            prev <= rx_q;
        end
    end

    assign rx_s = rx_q;
    assign fall = prev & ~rx_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with one-entry acknowledged holding register, framing and overrun reporting.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                      i_Clock,
    input  logic                      i_Rst_L,
    input  logic                      i_Rx_Serial,
    input  logic                      i_Rx_Ack,
    output logic                      o_Rx_DV,
    output logic [UART_DATA_BITS-1:0] o_Rx_Byte,
    output logic                      o_Rx_Active,
    output logic                      o_Rx_Frame_Err,
    output logic                      o_Rx_Overrun
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]      CNT_MID  = CNT_W'(uart_mid_bit(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [UART_IDX_W-1:0] IDX_LAST = UART_IDX_W'(UART_DATA_BITS - 1);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk       (i_Clock),
        .rst_n     (i_Rst_L),
        .rx_serial (i_Rx_Serial),
        .rx_s      (rx_s),
        .fall      (rx_fall)
    );

    uart_state_t               state;
    uart_state_t               state_nxt;
    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          count_nxt;
    logic [UART_IDX_W-1:0]     idx;
    logic [UART_IDX_W-1:0]     idx_nxt;
    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] shift_nxt;
    uart_hold_t                hold;
    uart_hold_t                hold_nxt;
    logic                      active;
    logic                      active_nxt;
    logic                      frame_err;
    logic                      frame_err_nxt;
    logic                      load_c;

    // Frame sequencing: start validation, mid-bit data sampling, stop check
    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        idx_nxt       = idx;
        shift_nxt     = shift;
        active_nxt    = active;
        frame_err_nxt = 1'b0;
        load_c        = 1'b0;

        case (state)
            s_IDLE: begin
                count_nxt = '0;
                idx_nxt   = '0;
                if (rx_fall) begin
                    state_nxt  = s_START;
                    active_nxt = 1'b1;
                end
            end

            s_START: begin
                if (count == CNT_MID) begin
                    count_nxt = '0;
                    if (!rx_s) begin
                        state_nxt = s_DATA;
                    end else begin
                        // Line went back high before mid-start: treat as a glitch
                        state_nxt  = s_IDLE;
                        active_nxt = 1'b0;
                    end
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end

            s_DATA: begin
                if (count == CNT_LAST) begin
                    count_nxt      = '0;
                    shift_nxt[idx] = rx_s;
                    if (idx == IDX_LAST) begin
                        idx_nxt   = '0;
                        state_nxt = s_STOP;
                    end else begin
                        idx_nxt = idx + UART_IDX_W'(1);
                    end
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end

            s_STOP: begin
                if (count == CNT_LAST) begin
                    count_nxt = '0;
                    state_nxt = s_CLEANUP;
                    if (rx_s) begin
                        load_c = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end

            s_CLEANUP: begin
                state_nxt  = s_IDLE;
                count_nxt  = '0;
                active_nxt = 1'b0;
            end

            default: begin
                state_nxt  = s_IDLE;
                count_nxt  = '0;
                idx_nxt    = '0;
                active_nxt = 1'b0;
            end
        endcase
    end

    // Holding register: a new byte always wins; an unacked overwrite raises overrun
    always_comb begin
        hold_nxt = hold;
        if (load_c) begin
            hold_nxt.data = shift;
            hold_nxt.dv   = 1'b1;
            if (hold.dv) begin
                hold_nxt.overrun = !i_Rx_Ack;
            end
        end else if (hold.dv && i_Rx_Ack) begin
            hold_nxt.dv      = 1'b0;
            hold_nxt.overrun = 1'b0;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state     <= s_IDLE;
            count     <= '0;
            idx       <= '0;
            shift     <= '0;
            hold      <= '0;
            active    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            idx       <= idx_nxt;
            shift     <= shift_nxt;
            hold      <= hold_nxt;
            active    <= active_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    assign o_Rx_DV        = hold.dv;
    assign o_Rx_Byte      = hold.data;
    assign o_Rx_Overrun   = hold.overrun;
    assign o_Rx_Active    = active;
    assign o_Rx_Frame_Err = frame_err;

endmodule
